elink_test_sequencer: RTL and testbench
=======================================

Name: elink_test_sequencer

Overview:
- Stimulus-side controller behind the elink2 loopback bench.
- On `start`, runs three phases in order: INIT first, then GOLD->ELINK2 and ELINK2->GOLD concurrently. Each phase is launched on a traffic engine.
- Collects engine completion/mismatch reports and drives the sticky done0..2 / error0..2 flags the top-level bench waits on.
- Enforces per-phase timeouts so `done == 3'b111` is always eventually reached.

Parameters:
- TIMEOUT_CYC, 65536: max cycles from a phase's go pulse to its done report; 0 disables timeout.
- CNT_W, 16: width of the saturating error counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  level; rising edge launches a run
- param_coreid  in  12  forwarded to engines, registered at launch
- coreid_q  out  12  coreid latched at start edge
- go  out  3  one-cycle launch pulses: [2]=INIT, [0]=GOLD->ELINK2, [1]=ELINK2->GOLD
- ph_done  in  3  one-cycle completion pulses from engines, same bit map
- ph_err  in  3  one-cycle mismatch pulses from engines, same bit map
- done0, done1, done2  out  1 each  sticky phase-complete flags
- error0, error1, error2  out  1 each  sticky phase-error flags
- err_count  out  CNT_W  saturating count of all accepted ph_err pulses plus timeouts
- busy  out  1  high from launch until all done bits set

Behaviour:
- Reset (async assert, sync release on aclk): state IDLE; go=0, done*=0, error*=0, err_count=0, busy=0, coreid_q=0; start_q=0.
- Start detection:
  - start_q registers start.
  - Launch condition: start & ~start_q in state IDLE or FIN.
  - Held-high start never relaunches.
- IDLE/FIN launch:
  - Clear done*, error*, err_count.
  - Latch coreid_q; set busy.
  - Next cycle: go[2]=1 for exactly one cycle; enter INIT.
- INIT:
  - Timer t2 counts from 0 on the go cycle.
  - ph_err[2] sets error2, err_count+1.
  - ph_done[2] sets done2, then go to DATA; go[0] and go[1] pulse together on the following cycle.
  - If ph_err[2] and ph_done[2] arrive in the same cycle, record both.
  - Timeout (t2 == TIMEOUT_CYC-1, no done): set error2, done2, err_count+1.
  - Abort: if error2 is set when INIT ends (error or timeout), skip DATA. Set done0, done1, error0, error1 in the same cycle (err_count not incremented for skipped phases) and enter FIN.
- DATA: two independent channels ch0 and ch1, each with its own timer, own flags, and the INIT rules above.
  - Channel i finished when done_i is set by ph_done[i] or timeout.
  - ph_err[i] after done_i is ignored: no flag, no count.
  - Enter FIN when both are finished. Same-cycle completion of both is legal and enters FIN that cycle+1.
- FIN: busy=0; all flags held until the next launch edge or reset.
- Out-of-state inputs: ph_done/ph_err for a phase not currently active are ignored.
- err_count:
  - Saturates at all-ones.
  - Two simultaneous error sources in one cycle add 2, saturating.
- Reset mid-run: all outputs return to reset values immediately; no go pulse is emitted on release.
- Latency: start edge sampled at cycle N -> go[2] at N+1; ph_done[2] at M -> done2 at M+1, go[1:0] at M+2; last data ph_done at K -> done bit at K+1, busy low at K+2.

Test Plan:
1. Nominal: reset 500 ns, start rises. Engines return ph_done[2] 20 cycles after go[2], ph_done[0] at 100 and ph_done[1] at 150 cycles after go[1:0] -> done goes 100, then 101, then 111; error=000; err_count=0; exactly one go pulse per bit.
2. Data mismatch: two ph_err[1] pulses before ph_done[1], one after -> error1=1 only, err_count=2, done=111.
3. INIT timeout: TIMEOUT_CYC=64, no ph_done[2] -> done2/error2 at go+64 cycles; same cycle done0=done1=error0=error1=1; go[1:0] never pulses; err_count=1.
4. Simultaneous events: ph_done[0], ph_done[1], ph_err[0] all in one cycle -> error0=1, err_count=1, done=111, busy drops next cycle.
5. Start handling: start held high through FIN produces no relaunch; toggling start low then high clears flags and err_count and reissues go[2]; start pulses while busy are ignored.
6. Async reset during DATA: aresetn low mid-cycle -> all outputs 0 immediately. After release with start already high (no edge) -> stays IDLE, no go.

Source files
------------

// File: rtl/elink_test_sequencer.sv
// elink_test_sequencer: launches the INIT phase, then the two data phases
// (GOLD->ELINK2 on channel 0, ELINK2->GOLD on channel 1) concurrently.
// It collects the engines' completion and mismatch pulses into sticky
// done/error flags and a saturating error count. A per-phase timeout
// guarantees that all three done flags are eventually set.
module elink_test_sequencer #(
  parameter int TIMEOUT_CYC = 65536,
  parameter int CNT_W       = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [11:0]      param_coreid,
  output logic [11:0]      coreid_q,
  output logic [2:0]       go,
  input  logic [2:0]       ph_done,
  input  logic [2:0]       ph_err,
  output logic             done0,
  output logic             done1,
  output logic             done2,
  output logic             error0,
  output logic             error1,
  output logic             error2,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int          TW      = 32;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DGO,
    S_DATA,
    S_FIN
  } state_t;

  state_t               state, state_n;
  logic                 start_q;
  logic                 start_armed, start_armed_n;
  logic [2:0]           go_n;
  logic [2:0]           done_r, done_n;
  logic [2:0]           error_r, error_n;
  logic [CNT_W-1:0]     cnt_n;
  logic                 busy_n;
  logic [11:0]          coreid_n;
  logic [2:0][TW-1:0]   tmr, tmr_n;
  logic                 launch;
  logic                 tmo2;
  logic [1:0]           tmo_d;
  logic [2:0]           inc;

  // True on the last allowed cycle of a phase; never true when disabled.
  function automatic logic expired(input logic [TW-1:0] t);
    return (TIMEOUT_CYC != 0) && (t == TO_LAST);
  endfunction

  // Adds up to seven error events to the counter, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                              input logic [2:0]       b);
    logic [CNT_W+2:0] s;
    s = {3'b000, a} + {{CNT_W{1'b0}}, b};
    if (s > {3'b000, {CNT_W{1'b1}}}) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Next-state and next-output logic for the phase sequencer.
  always_comb begin
    state_n       = state;
    start_armed_n = start_armed | ~start;
    go_n          = '0;
    done_n        = done_r;
    error_n       = error_r;
    cnt_n         = err_count;
    busy_n        = busy;
    coreid_n      = coreid_q;
    tmr_n         = tmr;
    tmo2          = 1'b0;
    tmo_d         = '0;
    inc           = '0;
    // A start level already high when reset releases is not an edge.
    launch        = start & ~start_q & start_armed;

    case (state)
      S_IDLE, S_FIN: begin
        if (state == S_FIN) busy_n = 1'b0;
        if (launch) begin
          done_n   = '0;
          error_n  = '0;
          cnt_n    = '0;
          coreid_n = param_coreid;
          busy_n   = 1'b1;
          go_n     = 3'b100;
          tmr_n[2] = '0;
          state_n  = S_INIT;
        end
      end

      S_INIT: begin
        tmr_n[2] = tmr[2] + TW'(1);
        tmo2     = expired(tmr[2]) & ~ph_done[2];
        inc      = {2'b00, ph_err[2]} + {2'b00, tmo2};
        if (ph_err[2] | tmo2) error_n[2] = 1'b1;
        if (ph_done[2] | tmo2) begin
          done_n[2] = 1'b1;
          if (error_n[2]) begin
            // A failed INIT makes the data phases meaningless: close them
            // out as errored without counting them.
            done_n[1:0]  = 2'b11;
            error_n[1:0] = 2'b11;
            state_n      = S_FIN;
          end else begin
            state_n = S_DGO;
          end
        end
      end

      S_DGO: begin
        go_n     = 3'b011;
        tmr_n[0] = '0;
        tmr_n[1] = '0;
        state_n  = S_DATA;
      end

      S_DATA: begin
        for (int i = 0; i < 2; i++) begin
          if (!done_r[i]) begin
            tmr_n[i] = tmr[i] + TW'(1);
            tmo_d[i] = expired(tmr[i]) & ~ph_done[i];
            inc      = inc + {2'b00, ph_err[i]} + {2'b00, tmo_d[i]};
            if (ph_err[i] | tmo_d[i])  error_n[i] = 1'b1;
            if (ph_done[i] | tmo_d[i]) done_n[i]  = 1'b1;
          end
        end
        if (&done_n[1:0]) state_n = S_FIN;
      end

      default: state_n = S_IDLE;
    endcase

    cnt_n = sat_add(cnt_n, inc);
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      go          <= '0;
      done_r      <= '0;
      error_r     <= '0;
      err_count   <= '0;
      busy        <= 1'b0;
      coreid_q    <= '0;
      tmr         <= '0;
    end else begin
      state       <= state_n;
      start_q     <= start;
      start_armed <= start_armed_n;
      go          <= go_n;
      done_r      <= done_n;
      error_r     <= error_n;
      err_count   <= cnt_n;
      busy        <= busy_n;
      coreid_q    <= coreid_n;
      tmr         <= tmr_n;
    end
  end

  assign done0  = done_r[0];
  assign done1  = done_r[1];
  assign done2  = done_r[2];
  assign error0 = error_r[0];
  assign error1 = error_r[1];
  assign error2 = error_r[2];

endmodule

// File: tb/tb_elink_test_sequencer.sv
// Bench for elink_test_sequencer: engine responders driven from per-run
// scenario tables, a scoreboard of expected go pulses and end-of-run flags,
// and a monitor that checks them as the DUT produces them.
module tb_elink_test_sequencer;

  localparam int T      = 48;
  localparam int CW     = 2;
  localparam int MAXOFF = T + 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic [11:0]   param_coreid;
  logic [11:0]   coreid_q;
  logic [2:0]    go;
  logic [2:0]    ph_done;
  logic [2:0]    ph_err;
  logic          done0, done1, done2, error0, error1, error2;
  logic [CW-1:0] err_count;
  logic          busy;

  elink_test_sequencer #(.TIMEOUT_CYC(T), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .param_coreid(param_coreid),
    .coreid_q(coreid_q), .go(go), .ph_done(ph_done), .ph_err(ph_err),
    .done0(done0), .done1(done1), .done2(done2),
    .error0(error0), .error1(error1), .error2(error2),
    .err_count(err_count), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [2:0] bits; int at; } go_exp_t;
  typedef struct {
    int d2_at; int done_at; int low_at; logic [2:0] err; int cnt; logic [11:0] cid;
  } fin_exp_t;

  go_exp_t  go_q[$];
  fin_exp_t fin_q[$];

  // Scenario: engine response offsets (cycles after the phase's go), -1 = none.
  int s_dn[3];
  int s_er[3][3];

  // Reference model: how a phase ends and how many errors it contributes.
  function automatic void phase_model(input int p, output int f, output int n);
    bit tmo;
    tmo = !(s_dn[p] >= 1 && s_dn[p] <= T - 1);
    f   = tmo ? T - 1 : s_dn[p];
    n   = tmo ? 1 : 0;
    for (int j = 0; j < 3; j++) begin
      bit dup = 0;
      for (int m = 0; m < j; m++) if (s_er[p][m] == s_er[p][j]) dup = 1;
      if (!dup && s_er[p][j] >= 1 && s_er[p][j] <= f) n++;
    end
  endfunction

  logic mon_en = 1'b0;
  logic busy_d = 1'b0;
  logic done2_d = 1'b0;
  int   d2_seen = -1;
  int   all_seen = -1;

  // Monitor: compares DUT activity against the scoreboard queues.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (go != 3'b000) begin
        if (go_q.size() == 0) begin
          check("unexpected_go", go, 0);
        end else begin
          go_exp_t ge;
          ge = go_q.pop_front();
          check("go_bits", go, ge.bits);
          check("go_cycle", cyc, ge.at);
          if (go[2]) begin
            check("flags_clear_at_launch",
                  {done2, done1, done0, error2, error1, error0, err_count}, 0);
            check("busy_at_launch", busy, 1);
            d2_seen  = -1;
            all_seen = -1;
          end
        end
      end
      if (done2 && !done2_d) d2_seen = cyc;
      if ({done2, done1, done0} == 3'b111 && all_seen < 0) all_seen = cyc;
      if (busy_d && !busy) begin
        if (fin_q.size() == 0) begin
          check("unexpected_busy_fall", busy_d, 0);
        end else begin
          fin_exp_t fe;
          fe = fin_q.pop_front();
          check("done2_cycle", d2_seen, fe.d2_at);
          check("all_done_cycle", all_seen, fe.done_at);
          check("busy_low_cycle", cyc, fe.low_at);
          check("done_bits", {done2, done1, done0}, 3'b111);
          check("error_bits", {error2, error1, error0}, fe.err);
          check("err_count", err_count, fe.cnt);
          check("coreid_q", coreid_q, fe.cid);
        end
      end
      busy_d  = busy;
      done2_d = done2;
    end
  end

  task automatic run_scen(input logic [11:0] cid, input bit toggle);
    int k, g1, f0, f1, f2, n0, n1, n2, cnt, o;
    int g2 = -1;
    int g01 = -1;
    bit fin_ok = 0;
    logic [2:0] pd, pe;
    fin_exp_t fe;
    @(negedge aclk); start = 1'b0;
    @(negedge aclk); start = 1'b1; param_coreid = cid;
    k = cyc + 1;
    go_q.push_back('{bits: 3'b100, at: k});
    phase_model(2, f2, n2);
    cnt      = n2;
    fe.d2_at = k + f2 + 1;
    fe.cid   = cid;
    if (n2 > 0) begin
      fe.err     = 3'b111;
      fe.done_at = k + f2 + 1;
      fe.low_at  = k + f2 + 2;
    end else begin
      g1 = k + f2 + 2;
      go_q.push_back('{bits: 3'b011, at: g1});
      phase_model(0, f0, n0);
      phase_model(1, f1, n1);
      cnt        = cnt + n0 + n1;
      fe.err     = {1'b0, n1 > 0, n0 > 0};
      fe.done_at = g1 + ((f0 > f1) ? f0 : f1) + 1;
      fe.low_at  = fe.done_at + 1;
    end
    fe.cnt = (cnt > 3) ? 3 : cnt;
    fin_q.push_back(fe);

    for (int it = 0; it < 4 * T + 60; it++) begin
      @(negedge aclk);
      if (it == 1) param_coreid = ~cid;
      pd = '0;
      pe = '0;
      if (go[2] && g2 < 0) g2 = cyc;
      if (go[0] && g01 < 0) g01 = cyc;
      if (g2 >= 0) begin
        o = cyc - g2;
        if (s_dn[2] == o) pd[2] = 1'b1;
        for (int j = 0; j < 3; j++) if (s_er[2][j] == o) pe[2] = 1'b1;
        if (toggle && o == 3) start = 1'b0;
        if (toggle && o == 4) start = 1'b1;
        if (g01 < 0 && $urandom_range(0, 5) == 0) begin
          pd[1:0] = 2'($urandom);
          pe[1:0] = 2'($urandom);
        end
      end
      if (g01 >= 0) begin
        o = cyc - g01;
        for (int i = 0; i < 2; i++) begin
          if (s_dn[i] == o) pd[i] = 1'b1;
          for (int j = 0; j < 3; j++) if (s_er[i][j] == o) pe[i] = 1'b1;
        end
      end
      ph_done = pd;
      ph_err  = pe;
      if (!busy && g2 >= 0 && cyc - g2 > MAXOFF && (g01 < 0 || cyc - g01 > MAXOFF)) begin
        fin_ok = 1;
        break;
      end
    end
    ph_done = '0;
    ph_err  = '0;
    check("run_completed", fin_ok, 1);
    check("go_queue_drained", go_q.size(), 0);
    check("fin_queue_drained", fin_q.size(), 0);
    go_q.delete();
    fin_q.delete();
  endtask

  task automatic reset_test();
    int   w;
    logic go_seen;
    mon_en = 1'b0;
    @(negedge aclk); start = 1'b0; param_coreid = 12'h5A5;
    @(negedge aclk); start = 1'b1;
    w = 0;
    while (!go[2] && w < 10) begin @(negedge aclk); w++; end
    repeat (4) @(negedge aclk);
    ph_done = 3'b100;
    @(negedge aclk); ph_done = '0;
    w = 0;
    while (!go[0] && w < 10) begin @(negedge aclk); w++; end
    check("reached_data", go, 3'b011);
    ph_err = 3'b001;
    @(negedge aclk); ph_err = '0;
    check("pre_reset_err_count", err_count, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_go", go, 0);
    check("rst_flags", {done2, done1, done0, error2, error1, error0}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_busy", busy, 0);
    check("rst_coreid", coreid_q, 0);
    @(negedge aclk); aresetn = 1'b1;
    go_seen = 1'b0;
    repeat (20) begin
      @(negedge aclk);
      if (go != 3'b000) go_seen = 1'b1;
    end
    check("no_go_after_release", go_seen, 0);
    check("idle_after_release", busy, 0);
    start = 1'b0;
  endtask

  initial begin
    aresetn      = 1'b0;
    start        = 1'b0;
    param_coreid = '0;
    ph_done      = '0;
    ph_err       = '0;
    #500;
    check("reset_state",
          {go, done2, done1, done0, error2, error1, error0, err_count, busy}, 0);
    check("reset_coreid", coreid_q, 0);
    @(negedge aclk); aresetn = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge aclk);

    // Nominal
    s_dn = '{30, 40, 20}; s_er = '{'{-1, -1, -1}, '{-1, -1, -1}, '{-1, -1, -1}};
    run_scen(12'h123, 1'b1);
    // Data mismatch: two errors before done1, one after
    s_dn = '{30, 40, 20}; s_er = '{'{-1, -1, -1}, '{10, 20, 45}, '{-1, -1, -1}};
    run_scen(12'hABC, 1'b0);
    // INIT timeout aborts the data phases
    s_dn = '{10, 10, -1}; s_er = '{'{-1, -1, -1}, '{-1, -1, -1}, '{-1, -1, -1}};
    run_scen(12'h001, 1'b1);
    // Both data dones and an error on the same cycle
    s_dn = '{25, 25, 20}; s_er = '{'{25, -1, -1}, '{-1, -1, -1}, '{-1, -1, -1}};
    run_scen(12'hFFF, 1'b0);
    // Counter saturation: timeout plus several errors
    s_dn = '{-1, 12, 8}; s_er = '{'{5, 6, 7}, '{8, -1, -1}, '{-1, -1, -1}};
    run_scen(12'h777, 1'b1);
    // INIT error and done on the same cycle
    s_dn = '{10, 10, 10}; s_er = '{'{-1, -1, -1}, '{-1, -1, -1}, '{10, -1, -1}};
    run_scen(12'h800, 1'b0);
    // Both data timeouts coincide with errors on their last cycle
    s_dn = '{-1, -1, 9}; s_er = '{'{T - 1, -1, -1}, '{T - 1, -1, -1}, '{-1, -1, -1}};
    run_scen(12'h0F0, 1'b1);
    // Early INIT error, then done, then an ignored late INIT error
    s_dn = '{10, 10, 15}; s_er = '{'{-1, -1, -1}, '{-1, -1, -1}, '{3, 16, -1}};
    run_scen(12'h3C3, 1'b0);
    // Done on the very last allowed cycle is not a timeout
    s_dn = '{T - 1, 5, 7}; s_er = '{'{-1, -1, -1}, '{-1, -1, -1}, '{-1, -1, -1}};
    run_scen(12'h456, 1'b1);

    for (int r = 0; r < 25; r++) begin
      for (int p = 0; p < 3; p++) begin
        s_dn[p] = ($urandom_range(0, 9) == 0) ? -1
                  : int'($urandom_range((p == 2) ? 5 : 1, T + 3));
        for (int j = 0; j < 3; j++)
          s_er[p][j] = ($urandom_range(0, 99) < ((p == 2) ? 8 : 30))
                       ? int'($urandom_range(1, T + 3)) : -1;
      end
      run_scen(12'($urandom), 1'($urandom));
    end

    reset_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
